// File: rtl/spi_flash_window.sv
// 8 kB read-only window onto an external SPI NOR flash, with a one-entry read cache.
// A window miss holds rdy low while a single-byte READ (0x03) runs in SPI mode 0.
module spi_flash_window #(
  parameter int SCK_HALF    = 2,
  parameter int WAKE_CYCLES = 48,
  parameter int CS_HIGH_MIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        win_cs,
  input  logic        reg_cs,
  input  logic        we,
  input  logic [12:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        rdy,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  // state     | meaning
  // WAKE      | cs low, shift release-power-down opcode 0xAB
  // WAKE_CS   | cs high after the wake opcode
  // WAKE_WAIT | count out the flash wake-up time
  // IDLE      | serve hits, launch a fetch on a window miss
  // CMD       | shift {0x03, fa} out on MOSI
  // DATA      | clock one byte in from MISO
  // FILL      | load the cache entry, cs high
  // GAP       | hold cs high before the next transaction
  typedef enum logic [2:0] {
    WAKE, WAKE_CS, WAKE_WAIT, IDLE, CMD, DATA, FILL, GAP
  } state_t;

  localparam logic [7:0]  HALF_RELOAD = 8'(SCK_HALF - 1);
  localparam logic [15:0] WAKE_RELOAD = 16'(WAKE_CYCLES - 1);
  localparam logic [15:0] GAP_RELOAD  = 16'(CS_HIGH_MIN - 1);

  state_t      state_q, state_d;
  logic [10:0] bank_q, bank_d;
  logic        valid_q, valid_d;
  logic [23:0] cache_addr_q, cache_addr_d;
  logic [7:0]  cache_data_q, cache_data_d;
  logic [7:0]  dout_q, dout_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  half_q, half_d;
  logic [15:0] wait_q, wait_d;

  logic [23:0] fa;
  logic        hit, miss, busy, shifting;
  logic        sck_tick, sck_rise, sck_fall, last_bit;
  logic [7:0]  reg_rdata;

  assign fa       = {bank_q, addr};
  assign hit      = valid_q & (cache_addr_q == fa);
  assign miss     = win_cs & ~we & ~hit;
  assign busy     = (state_q != IDLE);
  assign shifting = ((state_q == WAKE) & ~cs_n_q) | (state_q == CMD) | (state_q == DATA);
  assign sck_tick = shifting & (half_q == 8'd0);
  assign sck_rise = sck_tick & ~sclk_q;
  assign sck_fall = sck_tick & sclk_q;
  assign last_bit = (bit_cnt_q == 5'd0);

  assign rdy      = ~miss;
  assign dout     = dout_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  // The shift register MSB is the bit on the wire, so MOSI comes straight from a flop.
  assign spi_mosi = tx_q[31];

  always_comb begin
    case (addr[1:0])
      2'd0:    reg_rdata = bank_q[7:0];
      2'd1:    reg_rdata = {5'b0, bank_q[10:8]};
      2'd2:    reg_rdata = {6'b0, valid_q, busy};
      default: reg_rdata = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    valid_d      = valid_q;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;
    dout_d       = dout_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    half_d       = half_q;
    wait_d       = wait_q;

    if (shifting) begin
      if (sck_tick) begin
        half_d = HALF_RELOAD;
        sclk_d = ~sclk_q;
      end else begin
        half_d = half_q - 8'd1;
      end
      if (sck_fall) begin
        tx_d      = {tx_q[30:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 5'd1;
      end
    end

    case (state_q)
      WAKE: begin
        if (cs_n_q) begin
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          tx_d      = {8'hAB, 24'h0};
          bit_cnt_d = 5'd7;
          half_d    = HALF_RELOAD;
        end else if (sck_fall & last_bit) begin
          cs_n_d  = 1'b1;
          state_d = WAKE_CS;
        end
      end
      WAKE_CS: begin
        wait_d  = WAKE_RELOAD;
        state_d = WAKE_WAIT;
      end
      WAKE_WAIT: begin
        if (wait_q == 16'd0) state_d = IDLE;
        else                 wait_d  = wait_q - 16'd1;
      end
      IDLE: begin
        if (miss) begin
          cache_addr_d = fa;
          valid_d      = 1'b0;
          cs_n_d       = 1'b0;
          sclk_d       = 1'b0;
          tx_d         = {8'h03, fa};
          bit_cnt_d    = 5'd31;
          half_d       = HALF_RELOAD;
          state_d      = CMD;
        end
      end
      CMD: begin
        if (sck_fall & last_bit) begin
          bit_cnt_d = 5'd7;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (sck_rise) rx_d = {rx_q[6:0], spi_miso};
        if (sck_fall & last_bit) begin
          cs_n_d  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        cache_data_d = rx_q;
        valid_d      = 1'b1;
        wait_d       = GAP_RELOAD;
        state_d      = GAP;
      end
      GAP: begin
        if (wait_q == 16'd0) state_d = IDLE;
        else                 wait_d  = wait_q - 16'd1;
      end
      default: state_d = WAKE;
    endcase

    // Register writes override a same-edge FILL so a bank change is never left looking valid.
    if (reg_cs & we) begin
      case (addr[1:0])
        2'd0: begin
          bank_d[7:0] = din;
          valid_d     = 1'b0;
        end
        2'd1: begin
          bank_d[10:8] = din[2:0];
          valid_d      = 1'b0;
        end
        2'd3:    valid_d = 1'b0;
        default: ;
      endcase
    end

    if (win_cs & ~we & hit)  dout_d = cache_data_q;
    else if (reg_cs & ~we)   dout_d = reg_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAKE;
      bank_q       <= 11'h000;
      valid_q      <= 1'b0;
      cache_addr_q <= 24'h0;
      cache_data_q <= 8'h00;
      dout_q       <= 8'h00;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      tx_q         <= 32'h0;
      rx_q         <= 8'h00;
      bit_cnt_q    <= 5'd0;
      half_q       <= 8'd0;
      wait_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      valid_q      <= valid_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
      dout_q       <= dout_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      half_q       <= half_d;
      wait_q       <= wait_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_window.sv
// Bench for spi_flash_window: SPI flash model, queued expected SPI frames and read data.
module tb_spi_flash_window;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        win_cs = 1'b0;
  logic        reg_cs = 1'b0;
  logic        we = 1'b0;
  logic [12:0] addr = 13'h0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        rdy;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_flash_window dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .win_cs   (win_cs),
    .reg_cs   (reg_cs),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .rdy      (rdy),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          abort;
    int          nbits;
    int          cmd_bits;
    logic [31:0] cmd;
  } frame_t;

  frame_t     frame_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] flash_byte = 8'h00;
  int         bit_cnt = 0;
  logic [63:0] cap = '0;
  int         sclk_cnt = 0;
  int         cs_fall_cnt = 0;
  logic       take_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_wake();
    frame_t f;
    f.abort = 1'b0; f.nbits = 8; f.cmd_bits = 8; f.cmd = 32'h0000_00AB;
    frame_q.push_back(f);
  endfunction

  function automatic void push_read(input logic [23:0] fa);
    frame_t f;
    f.abort = 1'b0; f.nbits = 40; f.cmd_bits = 32; f.cmd = {8'h03, fa};
    frame_q.push_back(f);
  endfunction

  function automatic void push_abort();
    frame_t f;
    f.abort = 1'b1; f.nbits = 0; f.cmd_bits = 0; f.cmd = 32'h0;
    frame_q.push_back(f);
  endfunction

  // Flash model: mode 0, returns flash_byte after 32 command/address bits.
  always @(negedge spi_cs_n) begin
    bit_cnt = 0;
    cap = '0;
    if (mon_en) cs_fall_cnt++;
  end

  always @(posedge spi_sclk) begin
    sclk_cnt++;
    if (!spi_cs_n) begin
      cap = {cap[62:0], spi_mosi};
      bit_cnt++;
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_cs_n && bit_cnt >= 32 && bit_cnt < 40) spi_miso = flash_byte[39 - bit_cnt];
  end

  always @(posedge spi_cs_n) begin
    if (mon_en) begin
      frame_t      f;
      logic [63:0] mask;
      logic [31:0] got;
      if (frame_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spi_frame unexpected cs release, bits=%0d required=none", bit_cnt);
      end else begin
        f = frame_q.pop_front();
        if (f.abort) begin
          check("spi_abort_rst_low", 32'(rst_n), 32'h0);
        end else begin
          check("spi_frame_bits", 32'(bit_cnt), 32'(f.nbits));
          mask = (64'd1 << f.cmd_bits) - 64'd1;
          got  = 32'((cap >> (f.nbits - f.cmd_bits)) & mask);
          check("spi_frame_cmd", got, f.cmd);
        end
      end
    end
  end

  // Read monitor: dout is due the cycle after a read is accepted with rdy high.
  always @(posedge clk) take_q <= (win_cs | reg_cs) & ~we & rdy & rst_n;

  always @(negedge clk) begin
    if (take_q) begin
      logic [7:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout unexpected read, actual=%0h required=none", dout);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e));
      end
    end
  end

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_cs = 1'b1; we = 1'b1; addr = {11'h0, a}; din = d;
    @(negedge clk);
    reg_cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_cs = 1'b1; we = 1'b0; addr = {11'h0, a};
    exp_q.push_back(d);
    #1;
    check("reg_rd_rdy", 32'(rdy), 32'h1);
    @(negedge clk);
    reg_cs = 1'b0;
  endtask

  task automatic wr_win(input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    win_cs = 1'b1; we = 1'b1; addr = a; din = d;
    #1;
    check("win_wr_rdy", 32'(rdy), 32'h1);
    @(negedge clk);
    win_cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_win(input logic [12:0] a, input logic [7:0] d, input int smin, input int smax);
    int stall = 0;
    @(negedge clk);
    win_cs = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(d);
    #1;
    while (!rdy && stall < 1000) begin
      @(negedge clk);
      #1;
      stall++;
    end
    checks++;
    if (stall < smin || stall > smax) begin
      errors++;
      $display("FAIL rd_stall addr=%h actual=%0d required=%0d..%0d", a, stall, smin, smax);
    end
    @(negedge clk);
    win_cs = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int c0;
    int n;

    #2 rst_n = 1'b0;
    #10;
    mon_en = 1'b1;
    check("rst_cs_n", 32'(spi_cs_n), 32'h1);
    check("rst_sclk", 32'(spi_sclk), 32'h0);
    check("rst_mosi", 32'(spi_mosi), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_rdy", 32'(rdy), 32'h1);

    // Wake sequence: 0xAB, busy through the wake wait, then idle with an empty cache.
    push_wake();
    @(negedge clk);
    rst_n = 1'b1;
    rd_reg(2'd2, 8'h01);
    repeat (60) @(negedge clk);
    rd_reg(2'd2, 8'h01);
    repeat (40) @(negedge clk);
    rd_reg(2'd2, 8'h00);

    // Bank registers, upper bits of reg 1 read back as zero.
    wr_reg(2'd0, 8'h05);
    wr_reg(2'd1, 8'hFD);
    rd_reg(2'd1, 8'h05);
    rd_reg(2'd0, 8'h05);
    wr_reg(2'd1, 8'h00);
    rd_reg(2'd1, 8'h00);
    rd_reg(2'd3, 8'h00);

    // First miss: bank 5, offset 0x0123.
    flash_byte = 8'h5A;
    push_read(24'h00A123);
    rd_win(13'h0123, 8'h5A, 162, 162);

    // Repeat read hits with no SPI activity.
    s0 = sclk_cnt;
    rd_win(13'h0123, 8'h5A, 0, 0);
    check("hit_no_sclk", 32'(sclk_cnt), 32'(s0));
    repeat (4) @(negedge clk);
    rd_reg(2'd2, 8'h02);

    // Window write is ignored.
    s0 = sclk_cnt;
    c0 = cs_fall_cnt;
    wr_win(13'h0010, 8'h77);
    repeat (3) @(negedge clk);
    check("wwr_no_sclk", 32'(sclk_cnt), 32'(s0));
    check("wwr_no_cs", 32'(cs_fall_cnt), 32'(c0));
    check("wwr_cs_high", 32'(spi_cs_n), 32'h1);
    rd_win(13'h0123, 8'h5A, 0, 0);
    rd_reg(2'd2, 8'h02);

    // Bank change invalidates and refetches from the new bank.
    wr_reg(2'd0, 8'h06);
    rd_reg(2'd2, 8'h00);
    flash_byte = 8'hC3;
    push_read(24'h00C123);
    rd_win(13'h0123, 8'hC3, 162, 162);

    // Reg 3 write invalidates the same address.
    wr_reg(2'd3, 8'hFF);
    rd_reg(2'd2, 8'h00);
    flash_byte = 8'h3C;
    push_read(24'h00C123);
    rd_win(13'h0123, 8'h3C, 162, 162);

    // Top of flash: bank 0x7FF, offset 0x1FFF.
    wr_reg(2'd0, 8'hFF);
    wr_reg(2'd1, 8'h07);
    rd_reg(2'd0, 8'hFF);
    rd_reg(2'd1, 8'h07);
    flash_byte = 8'h81;
    push_read(24'hFFFFFF);
    rd_win(13'h1FFF, 8'h81, 162, 162);
    rd_win(13'h1FFF, 8'h81, 0, 0);

    // Reset in the middle of the command phase.
    push_abort();
    @(negedge clk);
    win_cs = 1'b1; we = 1'b0; addr = 13'h0042;
    n = 0;
    while (spi_cs_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_cs_low", 32'(spi_cs_n), 32'h0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_cs_async", 32'(spi_cs_n), 32'h1);
    check("abort_sclk", 32'(spi_sclk), 32'h0);
    check("abort_dout", 32'(dout), 32'h0);
    win_cs = 1'b0;
    repeat (3) @(negedge clk);
    push_wake();
    rst_n = 1'b1;
    rd_reg(2'd2, 8'h01);
    rd_reg(2'd0, 8'h00);
    rd_reg(2'd1, 8'h00);
    flash_byte = 8'h99;
    push_read(24'h000042);
    rd_win(13'h0042, 8'h99, 200, 300);

    repeat (10) @(negedge clk);
    check("frames_left", 32'(frame_q.size()), 32'h0);
    check("reads_left", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
